alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one ALU instance between two requesters (e.g. integer execute and branch-compare logic). It round-robin arbitrates valid/ready requests and registers the operands and control onto the ALU inputs. It then waits the ALU's fixed latency and returns the result and zero flag to the granted requester as a one-cycle response pulse. It sits between the requesters and the ALU's A/B/ALUControl inputs and R/zero outputs.

Parameters:
WIDTH, 32, operand/result width
ALU_LAT, 1, ALU result latency in cycles after its inputs change (0 = combinational ALU); legal range 0..7
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid_0  input  1  requester 0 has an operation
req_ready_0  output  1  requester 0 handshake accepted this cycle
req_a_0  input  WIDTH  requester 0 operand A
req_b_0  input  WIDTH  requester 0 operand B
req_op_0  input  3  requester 0 ALU control code
req_valid_1, req_ready_1, req_a_1, req_b_1, req_op_1  same as requester 0, for requester 1
rsp_valid  output  2  one-hot response strobe, bit i = requester i
rsp_r  output  WIDTH  result for the strobed requester
rsp_zero  output  1  zero flag for the strobed requester
alu_a  output  WIDTH  to ALU A
alu_b  output  WIDTH  to ALU B
alu_ctrl  output  3  to ALU ALUControl
alu_r  input  WIDTH  from ALU R
alu_zero  input  1  from ALU zero
busy  output  1  high when state != IDLE
op_count  output  CNT_W  completed operations, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): state=IDLE, alu_a/alu_b/alu_ctrl=0, rsp_valid=0, rsp_r=0, rsp_zero=0, op_count=0, last_grant=1 (so requester 0 wins first tie). Any in-flight operation is discarded and produces no response.
- States: IDLE, BUSY.
- IDLE arbitration (combinational):
  - One valid requester: it wins.
  - Both valid: the requester != last_grant wins.
  - req_ready_i = (state==IDLE) && grant==i. At most one ready is high. Ready never asserts in BUSY.
- Handshake on a rising edge with req_valid_i && req_ready_i:
  - alu_a<=req_a_i, alu_b<=req_b_i, alu_ctrl<=req_op_i.
  - owner<=i, last_grant<=i.
  - cnt<=ALU_LAT, state<=BUSY.
- BUSY: each edge with cnt!=0 decrements cnt. The edge with cnt==0 does all of the following:
  - rsp_r<=alu_r, rsp_zero<=alu_zero.
  - rsp_valid<=one-hot(owner), op_count<=op_count+1.
  - state<=IDLE.
- Timing: accept at edge k, capture at edge k+ALU_LAT+1. rsp_valid is high exactly one cycle. Next acceptance is at edge k+ALU_LAT+2 at the earliest. Throughput is 1 op per ALU_LAT+2 cycles.
- rsp_valid clears on the following edge. rsp_r/rsp_zero hold until the next capture.
- alu_a/alu_b/alu_ctrl hold their value from acceptance until the next acceptance. They are never changed in BUSY.
- A new request may be accepted in the same cycle rsp_valid is high (state is IDLE).
- last_grant changes only on a handshake. A requester dropping valid before ready does not alter priority.
- req_* inputs are ignored in BUSY. Requesters keep valid and data stable until ready.
- op_count wraps from 2^CNT_W-1 to 0.
- busy = (state==BUSY).

Test Plan:
- Bench ALU model: 3'b010=add, 3'b110=sub, latency ALU_LAT=1.
- Reset then single request: reset low 2 cycles, release; req 0 valid a=5, b=7, op=010 → req_ready_0 high in first IDLE cycle; rsp_valid=2'b01 two edges after acceptance; rsp_r=12, rsp_zero=0, op_count=1.
- Tie after reset: both valid, req0 a=9 b=9 op=110, req1 a=1 b=2 op=010 → req0 granted first (rsp_r=0, rsp_zero=1, rsp_valid=01), then req1 (rsp_r=3, rsp_valid=10). Acceptances are 3 cycles apart.
- Fairness: both requesters held valid for 6 ops → grants alternate 0,1,0,1,0,1, and ready is never asserted while busy=1.
- Reset mid-operation: assert reset one cycle after acceptance → rsp_valid stays 00, outputs zero. After release, a pending req1 is accepted before req0 if both valid? No: last_grant=1, so req0 is accepted first.
- Latency/wrap: ALU_LAT=0 and CNT_W=2, 5 ops → each response one edge after acceptance, and op_count sequence is 1,2,3,0,1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU between two requesters. A round-robin arbiter picks one
// valid request while idle, registers its operands and control onto the ALU
// inputs, waits the ALU's fixed latency, then returns the ALU result and zero
// flag to the winning requester as a one-cycle response strobe.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   req_valid_i/ready_i   per-requester handshake (i = 0, 1)
//   req_a_i, req_b_i      per-requester operands
//   req_op_i              per-requester ALU control code
//   rsp_valid             one-hot response strobe, bit i = requester i
//   rsp_r, rsp_zero       captured result and zero flag (held until next capture)
//   alu_a, alu_b, alu_ctrl  registered ALU inputs
//   alu_r, alu_zero       ALU outputs
//   busy                  operation in flight
//   op_count              completed operations, wraps
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrating; ready may assert for the winning valid requester
// BUSY  | ALU inputs held, counting down the ALU latency before capture
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [2:0]       req_op_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [2:0]       req_op_1,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       grant_vld;
    logic       accept;
    logic       done;

    // Round-robin: on a tie the requester that did not win last time goes.
    always_comb begin
        grant_vld = req_valid_0 | req_valid_1;
        grant     = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grant = ~last_grant;
        end else if (req_valid_1) begin
            grant = 1'b1;
        end
    end

    assign req_ready_0 = (state == IDLE) && grant_vld && !grant;
    assign req_ready_1 = (state == IDLE) && grant_vld &&  grant;
    assign busy        = (state == BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 3'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            rsp_valid  <= '0;
            rsp_r      <= '0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            rsp_valid <= '0;
            if (accept) begin
                alu_a      <= grant ? req_a_1  : req_a_0;
                alu_b      <= grant ? req_b_1  : req_b_0;
                alu_ctrl   <= grant ? req_op_1 : req_op_0;
                owner      <= grant;
                last_grant <= grant;
                cnt        <= LAT_INIT;
            end
            if (state == BUSY && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (done) begin
                rsp_r     <= alu_r;
                rsp_zero  <= alu_zero;
                rsp_valid <= {owner, ~owner};
                op_count  <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with a registered (1-cycle)
// ALU model, one with a combinational ALU and a 2-bit op counter.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    // instance A: ALU_LAT=1, CNT_W=16
    logic        v0 = 1'b0, v1 = 1'b0;
    logic        r0, r1;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0]  op0 = '0, op1 = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_r;
    logic        rsp_zero;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_r = '0;
    logic        alu_zero = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    // instance B: ALU_LAT=0, CNT_W=2
    logic        bv0 = 1'b0;
    logic        br0, br1;
    logic [31:0] ba0 = '0, bb0 = '0;
    logic [2:0]  bop0 = '0;
    logic [1:0]  b_rsp_valid;
    logic [31:0] b_rsp_r;
    logic        b_rsp_zero;
    logic [31:0] b_alu_a, b_alu_b;
    logic [2:0]  b_alu_ctrl;
    logic [31:0] b_alu_r;
    logic        b_alu_zero;
    logic        b_busy;
    logic [1:0]  b_op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        if (op == 3'b010) return a + b;
        if (op == 3'b110) return a - b;
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        alu_r    <= alu_f(alu_a, alu_b, alu_ctrl);
        alu_zero <= (alu_f(alu_a, alu_b, alu_ctrl) == 32'd0);
    end

    assign b_alu_r    = alu_f(b_alu_a, b_alu_b, b_alu_ctrl);
    assign b_alu_zero = (b_alu_r == 32'd0);

    alu_arbiter #(.WIDTH(32), .ALU_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid_0(v0), .req_ready_0(r0), .req_a_0(a0), .req_b_0(b0), .req_op_0(op0),
        .req_valid_1(v1), .req_ready_1(r1), .req_a_1(a1), .req_b_1(b1), .req_op_1(op1),
        .rsp_valid(rsp_valid), .rsp_r(rsp_r), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_r(alu_r), .alu_zero(alu_zero),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.WIDTH(32), .ALU_LAT(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid_0(bv0), .req_ready_0(br0), .req_a_0(ba0), .req_b_0(bb0), .req_op_0(bop0),
        .req_valid_1(1'b0), .req_ready_1(br1), .req_a_1(32'd0), .req_b_1(32'd0), .req_op_1(3'd0),
        .rsp_valid(b_rsp_valid), .rsp_r(b_rsp_r), .rsp_zero(b_rsp_zero),
        .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_ctrl(b_alu_ctrl),
        .alu_r(b_alu_r), .alu_zero(b_alu_zero),
        .busy(b_busy), .op_count(b_op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edges from the acceptance edge to the edge that raises rsp_valid.
    task automatic wait_rsp_a(output int n);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (rsp_valid == 2'b00 && n < 10);
    endtask

    int n;
    int g;
    int nrsp;
    int cyc;
    int exp_idx;
    int gidx;
    bit drop_pending;
    int q[$];
    logic [31:0] res [2];

    initial begin
        // reset and idle state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_rsp_r", rsp_r, 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        reset = 1'b1;

        // single request 5 + 7
        @(negedge clk); #1;
        v0 = 1'b1; a0 = 32'd5; b0 = 32'd7; op0 = 3'b010;
        #1;
        chk("single_ready0", 32'(r0), 32'd1);
        chk("single_ready1", 32'(r1), 32'd0);
        @(posedge clk); @(negedge clk); #1;
        v0 = 1'b0;
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_alu_a", alu_a, 32'd5);
        wait_rsp_a(n);
        chk("single_latency", 32'(n), 32'd2);
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_r", rsp_r, 32'd12);
        chk("single_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("single_op_count", 32'(op_count), 32'd1);
        @(negedge clk); #1;
        chk("single_rsp_clear", 32'(rsp_valid), 32'd0);
        chk("single_rsp_hold", rsp_r, 32'd12);

        // tie right after reset: requester 0 first
        reset = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        v0 = 1'b1; a0 = 32'd9; b0 = 32'd9; op0 = 3'b110;
        v1 = 1'b1; a1 = 32'd1; b1 = 32'd2; op1 = 3'b010;
        #1;
        chk("tie_ready0", 32'(r0), 32'd1);
        chk("tie_ready1", 32'(r1), 32'd0);
        @(posedge clk); @(negedge clk); #1;
        v0 = 1'b0;
        wait_rsp_a(n);
        chk("tie_latency0", 32'(n), 32'd2);
        chk("tie_rsp_valid0", 32'(rsp_valid), 32'd1);
        chk("tie_rsp_r0", rsp_r, 32'd0);
        chk("tie_rsp_zero0", 32'(rsp_zero), 32'd1);
        chk("tie_ready1_next", 32'(r1), 32'd1);
        @(posedge clk); @(negedge clk); #1;
        v1 = 1'b0;
        wait_rsp_a(n);
        chk("tie_rsp_valid1", 32'(rsp_valid), 32'd2);
        chk("tie_rsp_r1", rsp_r, 32'd3);
        chk("tie_rsp_zero1", 32'(rsp_zero), 32'd0);
        chk("tie_op_count", 32'(op_count), 32'd2);

        // fairness: both held valid for six operations
        res[0] = 32'd13;
        res[1] = 32'd7;
        a0 = 32'd10; b0 = 32'd3; op0 = 3'b010;
        a1 = 32'd10; b1 = 32'd3; op1 = 3'b110;
        @(negedge clk); #1;
        v0 = 1'b1; v1 = 1'b1;
        g = 0; nrsp = 0; cyc = 0; drop_pending = 0;
        while (nrsp < 6 && cyc < 60) begin
            #1;
            chk("ready_while_busy", 32'(busy & (r0 | r1)), 32'd0);
            if (rsp_valid != 2'b00) begin
                exp_idx = (q.size() > 0) ? q.pop_front() : 0;
                chk("fair_rsp_valid", 32'(rsp_valid), 32'(1 << exp_idx));
                chk("fair_rsp_r", rsp_r, res[exp_idx]);
                nrsp++;
            end
            if (drop_pending) begin
                v0 = 1'b0; v1 = 1'b0;
            end
            if ((r0 && v0) || (r1 && v1)) begin
                gidx = r1 ? 1 : 0;
                chk("fair_grant_order", 32'(gidx), 32'(g % 2));
                q.push_back(gidx);
                g++;
                if (g == 6) drop_pending = 1;
            end
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("fair_grants", 32'(g), 32'd6);
        chk("fair_responses", 32'(nrsp), 32'd6);
        chk("fair_op_count", 32'(op_count), 32'd8);

        // reset one cycle after acceptance drops the operation
        v0 = 1'b1; a0 = 32'd4; b0 = 32'd4; op0 = 3'b010;
        #1;
        chk("mid_ready0", 32'(r0), 32'd1);
        @(posedge clk); @(negedge clk); #1;
        v0 = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_op_count", 32'(op_count), 32'd0);
        chk("mid_rst_rsp_r", rsp_r, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        v0 = 1'b1; a0 = 32'd20; b0 = 32'd5; op0 = 3'b110;
        v1 = 1'b1; a1 = 32'd1;  b1 = 32'd1; op1 = 3'b010;
        reset = 1'b1;
        #1;
        chk("post_rst_ready0", 32'(r0), 32'd1);
        chk("post_rst_ready1", 32'(r1), 32'd0);
        @(posedge clk); @(negedge clk); #1;
        v0 = 1'b0;
        wait_rsp_a(n);
        chk("post_rst_rsp_valid0", 32'(rsp_valid), 32'd1);
        chk("post_rst_rsp_r0", rsp_r, 32'd15);
        @(posedge clk); @(negedge clk); #1;
        v1 = 1'b0;
        wait_rsp_a(n);
        chk("post_rst_rsp_valid1", 32'(rsp_valid), 32'd2);
        chk("post_rst_rsp_r1", rsp_r, 32'd2);
        chk("post_rst_op_count", 32'(op_count), 32'd2);

        // combinational ALU, 2-bit op counter wraps
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            bv0 = 1'b1; ba0 = 32'(i + 1); bb0 = 32'd2; bop0 = 3'b010;
            #1;
            chk("lat0_ready0", 32'(br0), 32'd1);
            @(posedge clk); @(negedge clk); #1;
            bv0 = 1'b0;
            n = 0;
            do begin
                @(negedge clk); #1;
                n++;
            end while (b_rsp_valid == 2'b00 && n < 8);
            chk("lat0_latency", 32'(n), 32'd1);
            chk("lat0_rsp_valid", 32'(b_rsp_valid), 32'd1);
            chk("lat0_rsp_r", b_rsp_r, 32'(i + 3));
            chk("lat0_op_count", 32'(b_op_count), 32'((i + 1) % 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
